// File: rtl/aether_register_bank.sv
// Parametrised config/status register bank: byte-strobed writes, RO constants, W1C status bits,
// shadowed registers with a busy-gated commit handshake, and a registered read port.
module aether_register_bank #(
    parameter int                             NumRegs      = 10,
    parameter int                             DataWidth    = 16,
    parameter int                             AddrWidth    = $clog2(NumRegs),
    parameter logic [NumRegs*DataWidth-1:0]   ResetValues  = '0,
    parameter logic [NumRegs-1:0]             ReadOnlyMask = NumRegs'(2'b11),
    parameter logic [NumRegs-1:0]             ShadowMask   = '0,
    parameter logic [NumRegs*DataWidth-1:0]   W1cMask      = '0
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             wr_en_i,
    input  logic [AddrWidth-1:0]             wr_addr_i,
    input  logic [DataWidth-1:0]             wr_data_i,
    input  logic [DataWidth/8-1:0]           wr_strb_i,
    output logic                             wr_err_o,
    input  logic                             rd_en_i,
    input  logic [AddrWidth-1:0]             rd_addr_i,
    output logic [DataWidth-1:0]             rd_data_o,
    output logic                             rd_valid_o,
    output logic                             rd_err_o,
    input  logic [NumRegs*DataWidth-1:0]     hw_set_i,
    input  logic                             commit_req_i,
    input  logic                             engine_busy_i,
    output logic                             commit_pending_o,
    output logic                             commit_done_o,
    output logic [NumRegs*DataWidth-1:0]     regs_o
);

    localparam int NumLanes = DataWidth / 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_COPY
    } state_e;

    state_e state_q, state_d;

    logic [NumRegs-1:0]           wr_sel;
    logic [DataWidth-1:0]         lane_mask;
    logic [NumRegs*DataWidth-1:0] staging_flat;
    logic                         copy_en;

    logic [DataWidth-1:0] rd_data_q, rd_data_d;
    logic                 rd_valid_q, rd_valid_d;
    logic                 rd_err_q, rd_err_d;
    logic                 wr_err_q, wr_err_d;
    logic                 commit_done_q, commit_done_d;

    // Write decode: only in-range, writable addresses select a register.
    always_comb begin
        wr_sel   = '0;
        wr_err_d = 1'b0;
        for (int i = 0; i < NumRegs; i++) begin
            wr_sel[i] = wr_en_i && (wr_addr_i == AddrWidth'(i)) && !ReadOnlyMask[i];
        end
        wr_err_d = wr_en_i && !(|wr_sel);
    end

    always_comb begin
        lane_mask = '0;
        for (int b = 0; b < NumLanes; b++) begin
            lane_mask[b*8 +: 8] = {8{wr_strb_i[b]}};
        end
    end

    assign copy_en = (state_q == ST_COPY);

    for (genvar i = 0; i < NumRegs; i++) begin : g_reg
        localparam logic [DataWidth-1:0] RstVal = ResetValues[i*DataWidth +: DataWidth];
        localparam logic [DataWidth-1:0] W1c    = W1cMask[i*DataWidth +: DataWidth];

        logic [DataWidth-1:0] staging_q, staging_d;
        logic [DataWidth-1:0] sw_mask;
        logic [DataWidth-1:0] sw_clr;

        // A hardware set wins over a same-cycle software clear on W1C bits.
        always_comb begin
            sw_mask   = wr_sel[i] ? lane_mask : '0;
            sw_clr    = sw_mask & wr_data_i;
            staging_d = (~W1c & ((sw_mask & wr_data_i) | (~sw_mask & staging_q)))
                      | (W1c & ((staging_q & ~sw_clr) | hw_set_i[i*DataWidth +: DataWidth]));
            if (ReadOnlyMask[i]) begin
                staging_d = RstVal;
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                staging_q <= RstVal;
            end else begin
                staging_q <= staging_d;
            end
        end

        assign staging_flat[i*DataWidth +: DataWidth] = staging_q;

        if (ShadowMask[i] && !ReadOnlyMask[i]) begin : g_shadow
            logic [DataWidth-1:0] active_q, active_d;

            // W1C bits follow staging on the same edge so the engine sees status immediately.
            always_comb begin
                active_d = ((copy_en ? staging_q : active_q) & ~W1c) | (staging_d & W1c);
            end

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    active_q <= RstVal;
                end else begin
                    active_q <= active_d;
                end
            end

            assign regs_o[i*DataWidth +: DataWidth] = active_q;
        end else begin : g_direct
            assign regs_o[i*DataWidth +: DataWidth] = staging_q;
        end
    end

    // Read port samples staging before this edge's write lands, so same-cycle RW returns old data.
    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_en_i;
        rd_err_d   = 1'b0;
        if (rd_en_i) begin
            rd_data_d = '0;
            rd_err_d  = 1'b1;
            for (int i = 0; i < NumRegs; i++) begin
                if (rd_addr_i == AddrWidth'(i)) begin
                    rd_data_d = staging_flat[i*DataWidth +: DataWidth];
                    rd_err_d  = 1'b0;
                end
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        commit_done_d = copy_en;
        unique case (state_q)
            ST_IDLE: begin
                if (commit_req_i) begin
                    state_d = engine_busy_i ? ST_WAIT : ST_COPY;
                end
            end
            ST_WAIT: begin
                if (!engine_busy_i) begin
                    state_d = ST_COPY;
                end
            end
            ST_COPY: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            rd_data_q     <= '0;
            rd_valid_q    <= 1'b0;
            rd_err_q      <= 1'b0;
            wr_err_q      <= 1'b0;
            commit_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rd_data_q     <= rd_data_d;
            rd_valid_q    <= rd_valid_d;
            rd_err_q      <= rd_err_d;
            wr_err_q      <= wr_err_d;
            commit_done_q <= commit_done_d;
        end
    end

    assign rd_data_o        = rd_data_q;
    assign rd_valid_o       = rd_valid_q;
    assign rd_err_o         = rd_err_q;
    assign wr_err_o         = wr_err_q;
    assign commit_done_o    = commit_done_q;
    assign commit_pending_o = (state_q != ST_IDLE);

endmodule

// File: doc/aether_register_bank.md
# aether_register_bank

Parametrised, address-mapped configuration/status register bank for the Aether engine instruction decoder. It generalises the fixed per-register flip-flop set into N registers of configurable width. It adds:
- byte-strobed writes
- read-only, write-1-to-clear and hardware-set status bits
- double-buffered (shadow) registers that the running engine only sees after a commit handshake
- a registered read port

## Interface
Parameters:
- `NumRegs`, 10, number of registers; addresses 0..NumRegs-1.
- `DataWidth`, 16, register width; must be a multiple of 8.
- `AddrWidth`, $clog2(NumRegs), width of address ports.
- `ResetValues`, all zero, packed NumRegs*DataWidth reset/constant values; register i occupies bits [i*DataWidth +: DataWidth].
- `ReadOnlyMask`, 'b11, NumRegs bits; bit i set means register i is a constant equal to its ResetValues slice.
- `ShadowMask`, '0, NumRegs bits; bit i set means register i is double-buffered.
- `W1cMask`, '0, NumRegs*DataWidth bits; set bits are status bits: hardware sets them, software clears them by writing 1.

Ports:
- `clk_i` input 1: clock.
- `rst_i` input 1: reset, asynchronous, active-high.
- `wr_en_i` input 1: write request.
- `wr_addr_i` input AddrWidth: write address.
- `wr_data_i` input DataWidth: write data.
- `wr_strb_i` input DataWidth/8: byte enables.
- `wr_err_o` output 1: one-cycle pulse when a write targets a read-only register or an out-of-range address.
- `rd_en_i` input 1: read request.
- `rd_addr_i` input AddrWidth: read address.
- `rd_data_o` output DataWidth: read data.
- `rd_valid_o` output 1: read data valid.
- `rd_err_o` output 1: read address out of range; qualified by rd_valid_o.
- `hw_set_i` input NumRegs*DataWidth: per-bit set requests; only W1C bits respond.
- `commit_req_i` input 1: request to copy staged values to the active copies.
- `engine_busy_i` input 1: engine running; a commit must wait while high.
- `commit_pending_o` output 1: a commit has been accepted but not yet applied.
- `commit_done_o` output 1: one-cycle pulse when the copy occurs.
- `regs_o` output NumRegs*DataWidth: active register values driven to the engine.

## Operation
- Each register has a staging copy; shadowed registers also have a separate active copy. For non-shadowed registers, active equals staging.
- Read-only registers are constants and never change.
- Write, when wr_en_i is high and the address is in range and writable: each byte lane with its strobe set updates that lane of the staging copy.
  - Non-W1C bits in the lane take wr_data_i.
  - W1C bits in the lane clear where wr_data_i is 1 and keep their value where it is 0.
- A write to a read-only register or an out-of-range address has no effect and pulses wr_err_o.
- W1C bits are set by hw_set_i every cycle. A hardware set and a software clear on the same bit in the same cycle leave the bit set.
- Read returns the staging value, so a shadowed register reads back what software wrote, not what the engine currently uses. Out-of-range reads return 0 with rd_err_o=1.
- Commit FSM states are IDLE, WAIT, COPY.
  - IDLE: on commit_req_i, go to COPY if engine_busy_i is low, otherwise go to WAIT.
  - WAIT: go to COPY on the first cycle engine_busy_i is low.
  - COPY: all shadowed active copies take their staging values as held before this clock edge, commit_done_o pulses, and the FSM returns to IDLE.
- commit_pending_o is high in WAIT and COPY.
- commit_req_i is ignored outside IDLE; repeat requests merge into the pending commit.
- A write in the COPY cycle updates staging only; it takes effect in the active copy at the next commit.
- W1C bits in shadowed registers bypass shadowing: the active copy of those bits always tracks staging.

## Timing
- Reset state, asynchronous: every staging and active copy holds its ResetValues slice. FSM is IDLE. rd_data_o=0, rd_valid_o=0, rd_err_o=0, wr_err_o=0, commit_pending_o=0, commit_done_o=0.
- A reset asserted mid-commit abandons the commit; active copies go to reset values.
- Write latency is 1 cycle: a write at edge N is visible in staging, rd_data, and regs_o for non-shadowed registers after edge N.
- Read latency is 1 cycle: rd_valid_o is high for exactly the cycle after rd_en_i.
  - A read and a write to the same address in the same cycle return the old value.
  - Back-to-back reads are supported at one per cycle.
- Commit latency when not busy: commit_req_i at edge N, COPY at edge N+1, so regs_o changes and commit_done_o is high after edge N+1.
- Busy throughout a commit: each cycle engine_busy_i stays high adds one cycle.
- wr_err_o is registered and pulses the cycle after the offending write.

## Test plan
- After reset, read all addresses: each returns its ResetValues slice; read address NumRegs returns 0 with rd_err_o=1.
- Write 0xABCD to shadowed register 3 with strobe 2'b10: readback is 0xAB00; regs_o[3] stays 0x0000 until commit, then becomes 0xAB00 and commit_done_o pulses once.
- Set engine_busy_i high, then commit_req_i: commit_pending_o is high for 5 busy cycles with regs_o unchanged; the copy happens 1 cycle after busy falls.
- Register 9 with W1C bit 0: hw_set_i[144]=1 makes bit 0 read 1. Writing 0x0001 clears it. A hardware set and a 0x0001 write in the same cycle leave it at 1.
- Write 0x1234 to read-only register 0: value is unchanged and wr_err_o pulses for one cycle.
- Assert rst_i mid-WAIT after staging 0x5555 in register 3: all outputs return to reset values and commit_done_o never pulses.
